dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the load/store strobes issued by the single-cycle CPU's main control decoder. It accepts one word access per instruction, holds the CPU with `stall` for a parameterised latency, then commits the write or returns the read data.
- Strobes `mem_enable`, `mem_read` and `mem_write` are active-low, exactly as the control decoder drives them.
- It sits between the datapath (ALU result = address, rt = write data) and the write-back mux (`mem_to_reg` path).

Parameters:
- ADDR_W, 10, word-address width; the array holds 2**ADDR_W words.
- DATA_W, 32, data word width.
- RD_LATENCY, 2, BUSY cycles for a read; must be >= 1.
- WR_LATENCY, 1, BUSY cycles for a write; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_enable  in  1  active-low access request.
- mem_read  in  1  active-low read strobe.
- mem_write  in  1  active-low write strobe.
- addr  in  32  byte address from the ALU.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  registered load data.
- stall  out  1  combinational; high = CPU must hold PC and the instruction.
- done  out  1  one-cycle pulse: access completed; the CPU advances at the end of this cycle.
- addr_err  out  1  one-cycle pulse together with `done` for a rejected request.

Behaviour:
- States: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` is used in BUSY.
- Reset (asynchronous) forces:
  - state = IDLE, cnt = 0, rdata = 0, done = 0, addr_err = 0.
  - Array contents are not reset.
- Request decode in IDLE:
  - `req = ~mem_enable & (~mem_read | ~mem_write)`.
  - If `mem_enable = 0` but both strobes are high, there is no request: no stall, no access.
- Illegal request: `req` with `addr[1:0] != 0`, or with both `mem_read` and `mem_write` low.
  - IDLE -> DONE; `done = addr_err = 1` in DONE.
  - No array access; rdata is unchanged.
- Legal request: IDLE -> BUSY with `cnt = LAT - 1`, where LAT is RD_LATENCY or WR_LATENCY.
  - The access type, word index `addr[ADDR_W+1:2]` and wdata are latched on this edge.
  - Address bits above ADDR_W+1 are ignored, so the address wraps modulo the array size.
- BUSY: decrement `cnt`; when `cnt = 0`, go to DONE.
  - On that same edge, a write commits to the array and a read loads rdata.
- DONE: `done = 1` for exactly one cycle, then unconditionally back to IDLE.
  - A back-to-back access is re-decoded in the following IDLE cycle.
- `stall = (IDLE & req) | BUSY`. It is low in DONE.
- Cycle counts:
  - Read: total stall = 1 + RD_LATENCY cycles; DONE occurs at request cycle + RD_LATENCY + 1.
  - Write: total stall = 1 + WR_LATENCY cycles.
  - Illegal request: 1 stall cycle.
- Strobe and address changes while in BUSY or DONE are ignored; the latched copies are used.
- rdata holds the last completed read until the next read completes. It is not updated by writes or errors.
- Read after write to the same address, issued in the next instruction, returns the new data.
- Reset asserted mid-access aborts it:
  - A write not yet at its commit edge is not performed.
  - stall drops immediately (asynchronous).

Decomposition:
- mem_pkg holds:
  - state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - STROBE_ACT = 1'b0;
  - the width of `cnt`.
- One sub-module, dmem_array: synchronous-write, synchronous-read single-port RAM (DATA_W x 2**ADDR_W) with we, re, idx, wd, rd.
- dmem_responder contains the FSM, the counter and the request latches.

Test Plan:
1. Reset, then write then read (defaults): `mem_enable=0, mem_write=0, addr=0x0000_0010, wdata=0xDEADBEEF`.
   - Expect stall high for 2 cycles, then a done pulse.
   - Then issue the read of 0x10: expect stall for 3 cycles, then `rdata = 0xDEADBEEF` in the DONE cycle.
2. Misaligned read at `addr=0x0000_0006`: expect stall for 1 cycle, then `done = addr_err = 1`, rdata unchanged, no array access.
3. Both strobes low at `addr=0x20`: expect addr_err pulse; a subsequent read of 0x20 returns the prior contents.
4. Wrap-around: write 0x12345678 at `addr=0x0000_1004`, then read at `addr=0x4`. With ADDR_W=10, expect `rdata = 0x12345678`.
5. Reset pulse during BUSY of a write of 0xA5A5A5A5 to 0x40, with RD_LATENCY=WR_LATENCY=4:
   - Expect stall=0 immediately and rdata=0.
   - A later read of 0x40 does not return 0xA5A5A5A5 (the location was preloaded with 0x0).
6. Back-to-back loads from 0x8 then 0xC (preloaded 0x11, 0x22): expect two done pulses, one IDLE cycle between them, and rdata sequence 0x11 then 0x22.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// strobe polarity and the latency counter width.
package mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  // The control decoder drives every memory strobe active-low.
  localparam logic STROBE_ACT = 1'b0;

  // Width of the BUSY down-counter; latencies up to 16 cycles fit.
  localparam int CNT_W = 4;

  // Counter preload for a latency of `lat` BUSY cycles (lat >= 1).
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// Only the read register is reset; the storage itself is not.
module dmem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Commit a write on the clock edge it is requested.
  // NOTE: the storage array is deliberately left out of reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  // Capture read data; the register holds its value until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd <= '0;
    else if (re) rd <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU: decodes the active-low
// load/store strobes, stalls the CPU for a fixed latency, then commits the
// write or returns the read data with a one-cycle done pulse.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,   // >= 1
  parameter int WR_LATENCY = 1    // >= 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              addr_err
);

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic                is_wr_q;
  logic                err_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wd_q;

  logic rd_act, wr_act, req, illegal, last_busy;

  // Address bits above the array index wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign rd_act    = (mem_read  == STROBE_ACT);
  assign wr_act    = (mem_write == STROBE_ACT);
  assign req       = (mem_enable == STROBE_ACT) && (rd_act || wr_act);
  assign illegal   = req && ((addr[1:0] != 2'b00) || (rd_act && wr_act));
  assign last_busy = (state == BUSY) && (cnt == '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode.
  // NOTE: next_state gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    if (req) next_state = illegal ? DONE : BUSY;
               else     next_state = IDLE;
      BUSY:    next_state = (cnt == '0) ? DONE : BUSY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the request on acceptance and run the latency counter in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
    end else if (state == IDLE && req) begin
      err_q <= illegal;
      if (!illegal) begin
        cnt     <= wr_act ? lat_load(WR_LATENCY) : lat_load(RD_LATENCY);
        is_wr_q <= wr_act;
        idx_q   <= addr[ADDR_W+1:2];
        wd_q    <= wdata;
      end
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    stall    = ((state == IDLE) && req) || (state == BUSY);
    done     = (state == DONE);
    addr_err = (state == DONE) && err_q;
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk (clk),
    .rst (rst),
    .we  (last_busy &&  is_wr_q),
    .re  (last_busy && !is_wr_q),
    .idx (idx_q),
    .wd  (wd_q),
    .rd  (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of accesses with expected
// results pushed to a scoreboard, plus hand sequences for back-to-back loads,
// the no-request case and reset in the middle of a write.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        mem_enable, mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata4;
  logic        stall0, stall4, done0, done4, err0, err4;
  bit          use4;
  int          cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder u_dut (
    .clk(clk), .rst(rst), .mem_enable(mem_enable), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .rdata(rdata0),
    .stall(stall0), .done(done0), .addr_err(err0)
  );

  dmem_responder #(.RD_LATENCY(4), .WR_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .mem_enable(mem_enable), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .rdata(rdata4),
    .stall(stall4), .done(done4), .addr_err(err4)
  );

  wire [31:0] cur_rdata = use4 ? rdata4 : rdata0;
  wire        cur_stall = use4 ? stall4 : stall0;
  wire        cur_done  = use4 ? done4  : done0;
  wire        cur_err   = use4 ? err4   : err0;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BOTH, OP_NONE} op_t;

  typedef struct {
    op_t         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    bit          scramble;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_enable = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
  endtask

  task automatic drive_op(input op_t op, input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    mem_enable = 1'b0;
    case (op)
      OP_RD:   begin mem_read = 1'b0; mem_write = 1'b1; end
      OP_WR:   begin mem_read = 1'b1; mem_write = 1'b0; end
      OP_BOTH: begin mem_read = 1'b0; mem_write = 1'b0; end
      default: begin mem_read = 1'b1; mem_write = 1'b1; end
    endcase
  endtask

  // Issue one access, count stall cycles until done, compare with the scoreboard.
  task automatic run_access(input vec_t v, input string tag, output int done_cyc);
    int   stalls;
    bit   got;
    exp_t e;
    stalls = 0;
    got    = 1'b0;
    done_cyc = -1;
    @(negedge clk);
    drive_op(v.op, v.addr, v.wdata);
    sb.push_back('{v.exp_err, v.exp_rdata, v.exp_stalls});
    #1;
    for (int c = 0; c < 40; c++) begin
      if (cur_done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (cur_stall) stalls++;
      if (c == 1 && v.scramble) begin
        addr      = $urandom;
        wdata     = $urandom;
        mem_read  = ~mem_read;
        mem_write = ~mem_write;
      end
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    check({tag, " done seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " stall cycles"}, 32'(stalls), 32'(e.stalls));
      check({tag, " addr_err"}, 32'(cur_err), 32'(e.err));
      check({tag, " rdata"}, cur_rdata, e.rdata);
      check({tag, " stall in DONE"}, 32'(cur_stall), 32'd0);
    end
    drive_idle();
  endtask

  int d1, d2, dummy;

  initial begin
    // Defaults: RD_LATENCY=2 (3 stall cycles), WR_LATENCY=1 (2 stall cycles).
    vecs[0]  = '{OP_WR,   32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 1'b0};
    vecs[1]  = '{OP_RD,   32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0};
    vecs[2]  = '{OP_RD,   32'h06,   32'h0,        1'b1, 32'hDEADBEEF, 1, 1'b0};
    vecs[3]  = '{OP_WR,   32'h12,   32'hBAD0BAD0, 1'b1, 32'hDEADBEEF, 1, 1'b0};
    vecs[4]  = '{OP_RD,   32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0};
    vecs[5]  = '{OP_WR,   32'h20,   32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 2, 1'b0};
    vecs[6]  = '{OP_BOTH, 32'h20,   32'h99999999, 1'b1, 32'hDEADBEEF, 1, 1'b0};
    vecs[7]  = '{OP_RD,   32'h20,   32'h0,        1'b0, 32'hCAFEF00D, 3, 1'b0};
    vecs[8]  = '{OP_WR,   32'h1004, 32'h12345678, 1'b0, 32'hCAFEF00D, 2, 1'b1};
    vecs[9]  = '{OP_RD,   32'h4,    32'h0,        1'b0, 32'h12345678, 3, 1'b0};
    vecs[10] = '{OP_WR,   32'h8,    32'h11,       1'b0, 32'h12345678, 2, 1'b0};
    vecs[11] = '{OP_WR,   32'hC,    32'h22,       1'b0, 32'h12345678, 2, 1'b0};
    vecs[12] = '{OP_RD,   32'h8,    32'h0,        1'b0, 32'h11,       3, 1'b1};

    use4  = 1'b0;
    rst   = 1'b1;
    rst4  = 1'b1;
    addr  = '0;
    wdata = '0;
    drive_idle();
    #1;
    check("reset rdata", rdata0, 32'h0);
    check("reset stall", 32'(stall0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset addr_err", 32'(err0), 32'd0);
    check("reset rdata lat4", rdata4, 32'h0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;

    // Enable low with both strobes high is not a request.
    @(negedge clk);
    drive_op(OP_NONE, 32'h10, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("no-req stall", 32'(stall0), 32'd0);
      check("no-req done", 32'(done0), 32'd0);
      @(negedge clk);
    end
    drive_idle();

    for (int i = 0; i < 13; i++)
      run_access(vecs[i], $sformatf("vec%0d", i), dummy);

    // Back-to-back loads: done pulses four cycles apart (DONE, IDLE, BUSY, BUSY, DONE).
    run_access('{OP_RD, 32'h8, 32'h0, 1'b0, 32'h11, 3, 1'b0}, "b2b first", d1);
    run_access('{OP_RD, 32'hC, 32'h0, 1'b0, 32'h22, 3, 1'b0}, "b2b second", d2);
    check("b2b done spacing", 32'(d2 - d1), 32'd4);

    // Latency-4 instance: reset in the middle of a write.
    use4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    run_access('{OP_WR, 32'h40, 32'h0,  1'b0, 32'h0,  5, 1'b0}, "lat4 preload 40", dummy);
    run_access('{OP_WR, 32'h44, 32'h55, 1'b0, 32'h0,  5, 1'b0}, "lat4 preload 44", dummy);
    run_access('{OP_RD, 32'h44, 32'h0,  1'b0, 32'h55, 5, 1'b0}, "lat4 read 44", dummy);

    @(negedge clk);
    drive_op(OP_WR, 32'h40, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("lat4 busy before reset", 32'(stall4), 32'd1);
    #2;
    rst4 = 1'b1;
    drive_idle();
    #1;
    check("mid-reset stall", 32'(stall4), 32'd0);
    check("mid-reset rdata", rdata4, 32'h0);
    check("mid-reset done", 32'(done4), 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    run_access('{OP_RD, 32'h40, 32'h0, 1'b0, 32'h0, 5, 1'b0}, "lat4 read 40 after abort", dummy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
